// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Turns a latency-1 FIFO pop/empty port into a valid/ready stream
//            through a 2-entry skid buffer. Define FIFO_READER_COUNT_EN to add
//            the 16-bit delivered-word counter and its m_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_req,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]           m_count
`endif
);

    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;

    logic                  w_take;
    logic [1:0]            w_level;
    logic [1:0]            w_keep;
    logic                  w_pop;

    // w_level is both the post-cycle occupancy and the committed-slot count
    // used to gate the next pop; it never exceeds 2 because a pop is only
    // issued when the slot it will land in is already reserved.
    assign w_take   = r_valid & m_ready;
    assign w_level  = r_occ + {1'b0, r_inflight} - {1'b0, w_take};
    assign w_keep   = r_occ - {1'b0, w_take};
    assign w_pop    = reset_n & ~fifo_empty & (w_level < 2'd2);

    assign fifo_req = w_pop;
    assign m_data   = r_head;
    assign m_valid  = r_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= w_pop;
            r_occ      <= w_level;
            r_valid    <= (w_level != 2'd0);
            if (w_take) begin
                r_head <= r_tail;
            end
            // Arriving word lands behind whatever survives this cycle's take.
            if (r_inflight) begin
                if (w_keep == 2'd0) begin
                    r_head <= fifo_data;
                end else begin
                    r_tail <= fifo_data;
                end
            end
        end
    end

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (w_take) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign m_count = r_count;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of FIFO word and output stream data.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-low.
REQ-004 fifo_data  input  DATA_WIDTH  FIFO read data; valid the cycle after a pop is issued.
REQ-005 fifo_empty  input  1  FIFO empty flag, same clock domain.
REQ-006 fifo_req  output  1  FIFO pop request; a pop occurs when fifo_req=1 and fifo_empty=0.
REQ-007 m_data  output  DATA_WIDTH  stream data, registered.
REQ-008 m_valid  output  1  stream valid, registered.
REQ-009 m_ready  input  1  stream ready from sink.
REQ-010 m_count  output  16  words delivered; present only with FIFO_READER_COUNT_EN.

Function
REQ-011 Block SHALL convert the FIFO pop/empty port (read latency 1) into a valid/ready stream, preserving word order, with no loss or duplication.
REQ-012 Transfer SHALL occur in any cycle where m_valid=1 and m_ready=1 (take).
REQ-013 Block SHALL contain a 2-entry buffer, occupancy occ in {0,1,2}, plus an in-flight flag inflight set in the cycle after a pop.
REQ-014 fifo_req SHALL equal (reset_n=1) and (fifo_empty=0) and (occ + inflight - take < 2); combinational path from m_ready to fifo_req is permitted.
REQ-015 In the cycle after a pop, fifo_data SHALL be written into the buffer tail; occ updates by +inflight -take, both allowed in one cycle.
REQ-016 m_valid SHALL be 1 iff occ >= 1; m_data SHALL present the head entry; head SHALL stay stable while m_valid=1 and m_ready=0.
REQ-017 Latency: FIFO non-empty in cycle N with occ=0, inflight=0 -> pop in N, m_valid=1 with that word in N+2.
REQ-018 Throughput: with fifo_empty=0 and m_ready=1 constantly, one word per cycle SHALL be delivered after the initial latency.
REQ-019 Backpressure: with m_ready=0, pops SHALL stop once occ+inflight=2; occ SHALL never exceed 2 (overflow impossible by construction).
REQ-020 Empty FIFO: fifo_req SHALL be 0 whenever fifo_empty=1; buffered words SHALL still drain.
REQ-021 Simultaneous capture and take at occ=2 SHALL not occur (guaranteed by REQ-014); capture and take at occ=1 SHALL leave occ=1 with the new word at head.

Reset
REQ-022 While reset_n=0 at a rising edge: occ=0, inflight=0, m_valid=0, m_data=0, m_count=0.
REQ-023 fifo_req SHALL be 0 whenever reset_n=0.
REQ-024 Reset mid-operation SHALL discard buffered and in-flight words; words already popped from the FIFO are lost; block resumes normally on the first cycle with reset_n=1.

Configuration
REQ-025 Macro FIFO_READER_COUNT_EN: when defined, m_count port and a 16-bit counter exist, incremented by 1 on each take, wrapping 65535 -> 0.
REQ-026 Without FIFO_READER_COUNT_EN, m_count port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Reset: reset_n=0 for 2 cycles with fifo_empty=0 -> fifo_req=0, m_valid=0, m_count=0 throughout.
REQ-028 Single word: FIFO holds 0xA5, m_ready=1 -> pop in cycle N, m_data=0xA5 with m_valid=1 in N+2 only, m_count=1.
REQ-029 Streaming: FIFO holds 0x00..0x3F, m_ready=1 -> 64 words in order on 64 consecutive cycles, m_count=64.
REQ-030 Backpressure: FIFO holds 0x10..0x17, m_ready=0 for 10 cycles -> exactly 2 pops, m_data=0x10 stable; then m_ready=1 -> 0x10..0x17 in order, no gaps.
REQ-031 Random m_ready (50%) and random fifo_empty over 10000 words -> scoreboard match, occ<=2, m_count=10000 mod 65536.
REQ-032 Mid-stream reset: reset_n=0 one cycle with occ=2 -> next cycle m_valid=0, occ=0; following words delivered in FIFO order, m_count restarts from 0.
